uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: recovers serial frames (1 start, DBITS data LSB-first, stop) from line rx.
//  Uses the shared 16x-oversampling baud tick s_tick; partner of the UART transmitter on the same link.
//  Presents each received byte on dout with a one-cycle rx_done_tick strobe to the consumer (FIFO/core).
// PARAMETERS
//  DBITS    8   data bits per frame (5..8)
//  SB_TICK  16  s_ticks spent in stop state (16/24/32 = 1/1.5/2 stop bits)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  rx           in   1      serial line, idle high, asynchronous to clk
//  s_tick       in   1      1-clk pulse at 16x baud rate
//  dout         out  DBITS  last received data word
//  rx_done_tick out  1      1-clk pulse: dout updated with a new word
//  frame_err    out  1      1-clk pulse coincident with rx_done_tick when stop bit sampled 0
//  parity_err   out  1      (only with UART_RX_PARITY_EN) pulse with rx_done_tick on parity mismatch
// BEHAVIOUR
//  - rx passes through 2-flop synchronizer (reset value 1); FSM sees rx_s only.
//  - Reset (async, reset=0): state=IDLE, counters 0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0.
//  - Sample counter s: width max(4,$clog2(SB_TICK)); bit counter n: $clog2(DBITS); shift reg b: DBITS.
//  - Counters advance only on cycles with s_tick=1; no s_tick => FSM holds.
//  - IDLE: on rx_s=0 -> START, s=0. (No s_tick needed to enter.)
//  - START: on s_tick, if s==7: rx_s=0 -> DATA, s=0, n=0; rx_s=1 -> IDLE (glitch reject, no strobe).
//           else s++.
//  - DATA: on s_tick, if s==15: s=0, b={rx_s,b[DBITS-1:1]} (LSB first); n==DBITS-1 -> STOP (or PARITY),
//          else n++. else s++. Sampling at s==15 after the s==7 start centre = mid-bit.
//  - STOP: on s_tick, if s==SB_TICK-1: sample rx_s; dout<=b, rx_done_tick=1 next clk,
//          frame_err=~rx_s (same cycle as done); -> IDLE. else s++.
//  - Outputs registered: rx_done_tick/frame_err/parity_err high exactly one clk, the cycle after the
//    s_tick that completes STOP. dout changes only in that same cycle; stable otherwise.
//  - Frame error still delivers dout and returns to IDLE; a line held low restarts START immediately.
//  - Back-to-back frames: IDLE->START with zero idle bits supported; no ticks lost.
//  - Reset mid-frame: partial word discarded, no strobe, dout returns to 0.
//  - Illegal state encoding -> IDLE.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: parameter PARITY_ODD (default 0 = even) added; PARITY state between
//   DATA and STOP: on s_tick at s==15 latch rx_s as parity bit, s=0 -> STOP; parity_err port exists,
//   pulses with rx_done_tick when XOR(data,parity) != PARITY_ODD. dout still delivered.
//  Not defined: no PARITY state, no parity_err port, DATA -> STOP directly.
// STRUCTURE
//  Shared package/header uart_defs: state encodings IDLE/START/DATA/PARITY/STOP, OVERSAMPLE=16,
//   START_MID=7, common to uart_tx and uart_rx.
//  Sub-module: uart_sync2 (2-flop synchronizer, param reset value) for rx.
//  Top: one registered state block + one combinational next-state block.
// TESTING
//  Bench: s_tick every 10 clk (16x), tx model drives rx; check with/without UART_RX_PARITY_EN.
//  1. Frame 0xA5, 1 stop -> one rx_done_tick, dout=8'hA5, frame_err=0; no further strobes.
//  2. rx low for 4 s_ticks then high -> no rx_done_tick, FSM back in IDLE, dout unchanged.
//  3. Back-to-back 0x00 then 0xFF, no idle gap -> two strobes, dout 8'h00 then 8'hFF.
//  4. Frame 0x3C with stop bit 0 -> rx_done_tick with frame_err=1, dout=8'h3C.
//  5. Reset asserted during data bit 4 of 0x81, then frame 0x5A -> no strobe for 0x81; dout=0 after
//     reset; next strobe dout=8'h5A.
//  6. (PARITY_EN, even) 0x07 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1, dout=8'h07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encodings and oversampling constants shared by the UART link blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

  // Receiver/transmitter FSM states. PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;  // s_ticks per bit period
  localparam int START_MID  = 7;   // s_tick index at the centre of the start bit

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs and received-word outputs of the UART receiver.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take each word on its rx_done_tick strobe.
// Ports: rx/s_tick into the receiver; dout, rx_done_tick, frame_err (and parity_err when
// UART_RX_PARITY_EN is defined) out of it. master = receiver, slave = line driver/consumer.
interface uart_rx_if #(
  parameter int DBITS = 8
);
  logic             rx;
  logic             s_tick;
  logic [DBITS-1:0] dout;
  logic             rx_done_tick;
  logic             frame_err;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    input  rx,
    input  s_tick,
    output dout,
    output rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output frame_err
  );

  modport slave (
    output rx,
    output s_tick,
    input  dout,
    input  rx_done_tick,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_sync2.sv
// uart_rx_sync2: two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk.
// Backpressure: none.
// Ports: clk, reset (async active-low), i_d (async input), o_q (synchronized output).
module uart_rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start + DBITS data (LSB first) [+ parity] + stop, 16x oversampled.
// Latency: word and status strobes appear 1 clk after the s_tick that completes the stop bit.
// Backpressure: none; every word is presented for exactly one clk on rx_done_tick.
// Ports: clk, reset (async active-low), bus (uart_rx_if.master: rx, s_tick in; dout,
// rx_done_tick, frame_err, parity_err out). Optional parity: define UART_RX_PARITY_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);

  localparam int SW = max_int(4, $clog2(SB_TICK));
  localparam int NW = $clog2(DBITS);

  uart_state_e      r_state;
  logic [SW-1:0]    r_s;
  logic [NW-1:0]    r_n;
  logic [DBITS-1:0] r_b;
  logic [DBITS-1:0] r_dout;
  logic             r_done;
  logic             r_ferr;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
  logic             r_perr;
`endif
  logic             w_rx_s;

  uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      // Status strobes are single-cycle; they are only raised on stop completion below.
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // Enter START on the level, not on a tick, so back-to-back frames lose nothing.
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_s     <= '0;
          end
        end

        ST_START: begin
          if (bus.s_tick) begin
            if (r_s == SW'(START_MID)) begin
              if (!w_rx_s) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                // Line went back high before mid start bit: treat as a glitch.
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (bus.s_tick) begin
            // s counts a full bit period from the start-bit centre, so this is mid-bit.
            if (r_s == SW'(OVERSAMPLE - 1)) begin
              r_s <= '0;
              r_b <= {w_rx_s, r_b[DBITS-1:1]};
              if (r_n == NW'(DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bus.s_tick) begin
            if (r_s == SW'(OVERSAMPLE - 1)) begin
              r_par   <= w_rx_s;
              r_s     <= '0;
              r_state <= ST_STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (bus.s_tick) begin
            if (r_s == SW'(SB_TICK - 1)) begin
              // The word is delivered even on a bad stop/parity bit; flags qualify it.
              r_dout  <= r_b;
              r_done  <= 1'b1;
              r_ferr  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
              r_perr  <= ((^{r_b, r_par}) != PARITY_ODD);
`endif
              r_state <= ST_IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dout         = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: serial line model drives randomized and directed frames into uart_rx;
// expected words are queued as frames are sent and checked when the receiver strobes.
// Build with and without UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BIT_CLK = 160;   // 16 s_ticks of 10 clk each
  localparam bit PODD    = 1'b0;  // even parity expected from the DUT default

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  uart_rx_if #(.DBITS(8)) u_if ();

  uart_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16x baud tick: one-clk pulse every 10 clk.
  initial begin
    u_if.s_tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      u_if.s_tick = 1'b1;
      @(negedge clk);
      u_if.s_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line-level transmitter model. A bad stop bit is released early so the receiver,
  // which re-arms on a low level, sees the line high again before its next look.
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                            input bit expect_it);
    exp_t e;
    logic par;
    par = (^d) ^ PODD ^ bad_par;
    if (expect_it) begin
      e.data = d;
      e.ferr = bad_stop;
`ifdef UART_RX_PARITY_EN
      e.perr = (((^d) ^ par) != PODD);
`else
      e.perr = 1'b0;
`endif
      exp_q.push_back(e);
    end
    u_if.rx = 1'b0;
    idle_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      idle_clk(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    u_if.rx = par;
    idle_clk(BIT_CLK);
`endif
    if (bad_stop) begin
      u_if.rx = 1'b0;
      idle_clk(120);
      u_if.rx = 1'b1;
      idle_clk(BIT_CLK - 120);
    end else begin
      u_if.rx = 1'b1;
      idle_clk(BIT_CLK);
    end
  endtask

  // Monitor: pops one expectation per strobe; flags stray strobes/flags and dout drift.
  initial begin
    exp_t e;
    logic [7:0] prev_dout;
    prev_dout = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (u_if.rx_done_tick) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got dout=%0h, expected no strobe (t=%0t)",
                     u_if.dout, $time);
          end else begin
            e = exp_q.pop_front();
            chk("dout", 32'(u_if.dout), 32'(e.data));
            chk("frame_err", 32'(u_if.frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
            chk("parity_err", 32'(u_if.parity_err), 32'(e.perr));
`endif
          end
        end else begin
          if (u_if.frame_err) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_frame_err: got 1, expected 0 (t=%0t)", $time);
          end
`ifdef UART_RX_PARITY_EN
          if (u_if.parity_err) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_parity_err: got 1, expected 0 (t=%0t)", $time);
          end
`endif
          if (u_if.dout !== prev_dout) begin
            n_cmp++;
            n_err++;
            $display("FAIL dout_stable: got %0h, expected %0h (t=%0t)", u_if.dout, prev_dout,
                     $time);
          end
        end
      end
      prev_dout = u_if.dout;
    end
  end

  initial begin
    logic [7:0] d;
    bit         bs;
    bit         bp;

    reset   = 1'b0;
    u_if.rx = 1'b1;
    idle_clk(5);
    chk("reset_dout", 32'(u_if.dout), 32'h0);
    chk("reset_done", 32'(u_if.rx_done_tick), 32'h0);
    chk("reset_ferr", 32'(u_if.frame_err), 32'h0);
    reset = 1'b1;
    idle_clk(200);

    // 1: single clean frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_clk(2 * BIT_CLK);

    // 2: short low pulse (4 ticks) must be rejected
    u_if.rx = 1'b0;
    idle_clk(40);
    u_if.rx = 1'b1;
    idle_clk(200);
    chk("glitch_dout", 32'(u_if.dout), 32'hA5);
    chk("glitch_state", 32'(dut.r_state), 32'(ST_IDLE));

    // 3: back-to-back, no idle bits
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle_clk(BIT_CLK);

    // 4: bad stop bit
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle_clk(2 * BIT_CLK);

    // 5: reset in the middle of data bit 4 of 0x81, then a clean frame
    d = 8'h81;
    u_if.rx = 1'b0;
    idle_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = d[i];
      idle_clk(BIT_CLK);
    end
    u_if.rx = d[4];
    idle_clk(BIT_CLK / 2);
    reset = 1'b0;
    idle_clk(3);
    u_if.rx = 1'b1;
    idle_clk(3);
    chk("midreset_dout", 32'(u_if.dout), 32'h0);
    chk("midreset_done", 32'(u_if.rx_done_tick), 32'h0);
    reset = 1'b1;
    idle_clk(2 * BIT_CLK);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle_clk(BIT_CLK);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07, correct then wrong parity bit
    send_frame(8'h07, 1'b0, 1'b0, 1'b1);
    idle_clk(BIT_CLK);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);
    idle_clk(BIT_CLK);
`endif

    // Randomized frames with random gaps (including none)
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom_range(0, 255));
      bs = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
      bp = ($urandom_range(0, 3) == 0);
`else
      bp = 1'b0;
`endif
      send_frame(d, bs, bp, 1'b1);
      idle_clk($urandom_range(0, 300));
    end

    idle_clk(3 * BIT_CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
